// File: rtl/debounce_edge.sv
// debounce_edge: synchroniser plus consecutive-sample debouncer giving a clean level and rise/fall pulses.
// A held input reaches o_level after SYNC_STAGES+DEBOUNCE_CYCLES edges; DEBOUNCE_LONG_PRESS_EN adds o_long.
module debounce_edge #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned CNT_W           = 16,
   parameter logic        RESET_LEVEL     = 1'b0,
   parameter int unsigned LONG_CYCLES     = 50000,
   parameter int unsigned LONG_W          = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise,
   output logic o_fall,
`ifdef DEBOUNCE_LONG_PRESS_EN
   output logic o_long,
`endif
   output logic o_busy
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_edge: SYNC_STAGES must be 2 or more");
   end
   if (DEBOUNCE_CYCLES < 1 || (64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt
      $error("debounce_edge: DEBOUNCE_CYCLES must be >= 1 and fit in CNT_W bits");
   end
   if ((64'd1 << LONG_W) <= 64'(LONG_CYCLES)) begin : g_bad_long
      $error("debounce_edge: LONG_CYCLES must fit in LONG_W bits");
   end

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   level_d;
   logic                   accept;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Any sample matching the current level drops the count back to zero.
   always_comb begin
      cnt_d   = '0;
      level_d = o_level;
      accept  = 1'b0;
      if (s != o_level) begin
         if (cnt_q == CNT_LAST) begin
            accept  = 1'b1;
            level_d = s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_level <= RESET_LEVEL;
         cnt_q   <= '0;
         o_rise  <= 1'b0;
         o_fall  <= 1'b0;
         o_busy  <= 1'b0;
      end else begin
         o_level <= level_d;
         cnt_q   <= cnt_d;
         o_rise  <= accept & s;
         o_fall  <= accept & ~s;
         o_busy  <= (cnt_d != '0);
      end
   end

`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);

   logic [LONG_W-1:0] long_q;
   logic [LONG_W-1:0] long_d;

   // Saturating at LONG_MAX keeps a single pulse per press.
   always_comb begin
      long_d = '0;
      if (o_level) begin
         long_d = (long_q == LONG_MAX) ? long_q : long_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         long_q <= '0;
         o_long <= 1'b0;
      end else begin
         long_q <= long_d;
         o_long <= (long_d == LONG_MAX) && (long_q != LONG_MAX);
      end
   end
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge: directed scenarios then random runs against a windowed reference model.
module tb_debounce_edge;
   localparam int SYNC  = 2;
   localparam int DC    = 4;
   localparam int LONGC = 10;
   localparam int MAXC  = 4096;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   logic i_raw = 1'b0;
   logic o_level, o_rise, o_fall, o_busy;
`ifdef DEBOUNCE_LONG_PRESS_EN
   logic o_long;
`endif

   debounce_edge #(
      .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC), .CNT_W(16), .RESET_LEVEL(1'b0),
      .LONG_CYCLES(LONGC), .LONG_W(16)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_raw),
      .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall),
`ifdef DEBOUNCE_LONG_PRESS_EN
      .o_long(o_long),
`endif
      .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state: raw value applied before each edge, plus event edges.
   bit raw_hist [MAXC];
   int k         = 0;
   int last_rst  = -1000;
   int last_flip = -1000;
   int rise_k    = -100000;
   bit m_level   = 1'b0;
   bit m_rise, m_fall, m_busy, m_long;

   int obs_rise_k, obs_fall_k, obs_long_k;
   int n_obs_rise, n_obs_fall, n_obs_long, busy_cycles;
   int start;

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s at edge %0d: observed %0b, expected %0b", tag, k, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s at edge %0d: observed %0d, expected %0d", tag, k, obs, exp);
      end
   endtask

   task automatic clr_obs();
      obs_rise_k  = -1;
      obs_fall_k  = -1;
      obs_long_k  = -1;
      n_obs_rise  = 0;
      n_obs_fall  = 0;
      n_obs_long  = 0;
      busy_cycles = 0;
   endtask

   // Value at the synchroniser output seen by edge e: raw from SYNC edges earlier,
   // or the reset level if that sample was taken at or before the last reset.
   function automatic bit s_seen(input int e);
      if (e - SYNC > last_rst) return raw_hist[e - SYNC];
      return 1'b0;
   endfunction

   task automatic step(input bit raw, input bit rst);
      int m;
      bit old_level;
      @(negedge i_clk);
      i_raw = raw;
      i_rst = rst;
      @(posedge i_clk);
      k++;
      raw_hist[k] = raw;
      old_level = m_level;
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_busy = 1'b0;
      m_long = 1'b0;
      if (rst) begin
         m_level   = 1'b0;
         last_rst  = k;
         last_flip = k;
         rise_k    = -100000;
      end else begin
         // Level flips once DC consecutive samples since the last change disagree with it.
         m = 0;
         while (m < DC && (k - m) > last_flip && s_seen(k - m) != m_level) m++;
         if (m == DC) begin
            m_level   = !m_level;
            m_rise    = m_level;
            m_fall    = !m_level;
            last_flip = k;
            if (m_level) rise_k = k;
         end else begin
            m_busy = (m != 0);
         end
         m_long = old_level && (k - rise_k == LONGC);
      end
      #1;
      chk_b("level", o_level, m_level);
      chk_b("rise", o_rise, m_rise);
      chk_b("fall", o_fall, m_fall);
      chk_b("busy", o_busy, m_busy);
      chk_b("rise_fall_excl", o_rise & o_fall, 1'b0);
`ifdef DEBOUNCE_LONG_PRESS_EN
      chk_b("long", o_long, m_long);
      if (o_long) begin n_obs_long++; obs_long_k = k; end
`endif
      if (o_rise) begin n_obs_rise++; obs_rise_k = k; end
      if (o_fall) begin n_obs_fall++; obs_fall_k = k; end
      if (o_busy) busy_cycles++;
   endtask

   initial begin
      clr_obs();

      // Reset held with raw high, then released with raw low.
      repeat (3) step(1'b1, 1'b1);
      repeat (4) step(1'b0, 1'b0);

      // Clean rise.
      clr_obs();
      start = k + 1;
      repeat (10) step(1'b1, 1'b0);
      chk_i("rise_latency", obs_rise_k - start, 5);
      chk_i("rise_count", n_obs_rise, 1);
      chk_i("rise_busy_cycles", busy_cycles, 3);
      chk_i("rise_no_fall", n_obs_fall, 0);

      // Clean fall.
      clr_obs();
      start = k + 1;
      repeat (10) step(1'b0, 1'b0);
      chk_i("fall_latency", obs_fall_k - start, 5);
      chk_i("fall_count", n_obs_fall, 1);
      chk_i("fall_no_rise", n_obs_rise, 0);

      // Glitch of DC-1 samples is rejected.
      clr_obs();
      repeat (3) step(1'b1, 1'b0);
      repeat (8) step(1'b0, 1'b0);
      chk_i("glitch_no_rise", n_obs_rise, 0);
      chk_i("glitch_busy_cycles", busy_cycles, 3);
      chk_b("glitch_level", o_level, 1'b0);
      chk_b("glitch_busy_end", o_busy, 1'b0);

      // Bounce 0,1,0,0,0,0 on a falling level delays acceptance by two edges.
      repeat (10) step(1'b1, 1'b0);
      clr_obs();
      start = k + 1;
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (8) step(1'b0, 1'b0);
      chk_i("bounce_fall_latency", obs_fall_k - start, 7);
      chk_i("bounce_fall_count", n_obs_fall, 1);

      // Reset lands on the fourth edge of a count in progress.
      clr_obs();
      repeat (3) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      chk_i("rstmid_no_rise", n_obs_rise, 0);
      chk_b("rstmid_level", o_level, 1'b0);
      chk_b("rstmid_busy", o_busy, 1'b0);
      start = k + 1;
      repeat (8) step(1'b1, 1'b0);
      chk_i("rstmid_restart_latency", obs_rise_k - start, 5);

`ifdef DEBOUNCE_LONG_PRESS_EN
      // Long press: one pulse LONGC cycles after the rise, no repeat.
      repeat (10) step(1'b0, 1'b0);
      clr_obs();
      repeat (30) step(1'b1, 1'b0);
      chk_i("long_count", n_obs_long, 1);
      chk_i("long_offset", obs_long_k - obs_rise_k, LONGC);
`endif

      // Random runs with occasional resets.
      for (int r = 0; r < 300; r++) begin
         bit v;
         int len;
         v   = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 8));
         if ($urandom_range(0, 49) == 0) step(v, 1'b1);
         for (int j = 0; j < len; j++) step(v, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Conditioning stage upstream of the team's plain sampling flops.
- Takes a raw asynchronous level input, such as a pushbutton or switch, and synchronises it into i_clk.
- Debounces it with a consecutive-sample counter.
- Delivers a clean registered level plus single-cycle rise and fall pulses that downstream registers consume directly.

Parameters:
SYNC_STAGES, 2, synchroniser depth; legal values are 2 or more.
DEBOUNCE_CYCLES, 1000, consecutive differing synchronised samples needed before the level is accepted; legal values are 1 or more.
CNT_W, 16, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
RESET_LEVEL, 1'b0, value loaded into the synchroniser chain and o_level on reset.
LONG_CYCLES, 50000, long-press threshold in cycles; used only with the optional feature.
LONG_W, 16, long-press counter width; must satisfy 2^LONG_W > LONG_CYCLES.

Ports:
i_clk  input  1  system clock; all logic is on the rising edge.
i_rst  input  1  reset, synchronous and active-high.
i_raw  input  1  raw asynchronous input; no timing relation to i_clk.
o_level  output  1  debounced level, registered.
o_rise  output  1  one-cycle pulse when o_level goes 0->1.
o_fall  output  1  one-cycle pulse when o_level goes 1->0.
o_busy  output  1  high while a candidate change is being counted (counter nonzero).
o_long  output  1  optional feature only: one-cycle long-press pulse.

Behaviour:
- Reset, sampled on the i_clk edge while i_rst=1:
  - every synchroniser stage and o_level = RESET_LEVEL;
  - debounce counter = 0;
  - o_rise = o_fall = o_busy = 0;
  - long counter = 0 and o_long = 0.
- Reset overrides all other activity. A count in progress when reset arrives is discarded and produces no pulse.
- Synchroniser: i_raw shifts through a chain of SYNC_STAGES flops. Its last stage is s.
- Debounce, evaluated every edge with i_rst=0:
  - s == o_level: counter = 0.
  - s != o_level and counter < DEBOUNCE_CYCLES-1: counter increments by 1.
  - s != o_level and counter == DEBOUNCE_CYCLES-1:
    - o_level <= s and counter = 0;
    - o_rise <= s, o_fall <= ~s on that same edge.
- Equivalent two-state view: STABLE (counter=0) and COUNTING (counter>0). Any sample where s equals o_level returns to STABLE.
- The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- DEBOUNCE_CYCLES=1: the level is accepted on the first differing sample, and the counter stays 0.
- o_rise and o_fall:
  - registered;
  - high for exactly the one cycle in which o_level has just changed;
  - otherwise 0;
  - never high together.
- o_busy is registered and equals (counter != 0) after each edge.
- Latency:
  - an i_raw change held steady reaches o_level after SYNC_STAGES + DEBOUNCE_CYCLES edges, counted from the first edge that samples the new value;
  - a pulse of fewer than DEBOUNCE_CYCLES samples at s causes no change and no pulse.
- Bounce during counting: the counter restarts from 0 on the first sample that matches o_level. Back-to-back accepted edges are separated by at least DEBOUNCE_CYCLES cycles.
- i_raw is never used combinationally. All outputs are flop outputs.

Optional Feature:
- Macro: DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - port o_long exists;
  - the long counter counts each cycle that o_level==1 and clears whenever o_level==0;
  - when the counter reaches LONG_CYCLES, o_long pulses high for exactly one cycle, then the counter holds at LONG_CYCLES until o_level falls, so there is no repeat;
  - o_long is 0 in reset.
- Undefined: port o_long, the long counter and its logic are absent, and all other behaviour is unchanged.

Test Plan:
Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0, LONG_CYCLES=10.
1. Reset: i_raw=1, i_rst=1 for 3 edges -> o_level=0, o_rise=o_fall=o_busy=0 during and on the first edge after release.
2. Clean rise:
   - stimulus: i_raw 0->1 held;
   - o_level=1 after exactly 6 edges from the first sampling edge;
   - o_rise=1 for that one cycle, o_fall=0 throughout;
   - o_busy=1 for cycles 3-5.
3. Glitch: i_raw=1 for 3 cycles then back to 0 -> o_level stays 0, no pulse, o_busy rises and then returns to 0.
4. Clean fall after test 2: i_raw 1->0 held -> o_level=0 after 6 edges and o_fall=1 for one cycle. Bounce pattern 0,1,0,0,0,0 at s -> counter restarts and the acceptance is delayed by the bounce.
5. Reset mid-count: i_raw=1, then i_rst=1 on the 4th edge -> no o_rise, o_level=0, o_busy=0; the count restarts from 0 after release.
6. With DEBOUNCE_LONG_PRESS_EN: i_raw high for 30 cycles -> o_long=1 for exactly one cycle, 10 cycles after o_rise, with no second pulse. Without the macro, the build has no o_long port.
